// File: rtl/pc_unit_ras.sv
// Program-counter unit: next-PC selection, exception entry/return (EPC)
// and a circular return-address stack with overflow/underflow flags.
module pc_unit_ras #(
   parameter int                ADDR_W       = 32,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
   parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h0000_0180),
   parameter int                RAS_DEPTH    = 4
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              PCWre,
   input  logic [2:0]        PCSrc,
   input  logic [15:0]       Immediate,
   input  logic [ADDR_W-1:0] dataFromRs,
   input  logic [25:0]       JumpIdx,
   input  logic              push_ra,
   input  logic              exc_req,
   output logic [ADDR_W-1:0] Address,
   output logic [ADDR_W-1:0] nextPC,
   output logic [ADDR_W-1:0] PC_add_4,
   output logic [3:0]        PC4,
   output logic [ADDR_W-1:0] EPC,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_ovf,
   output logic              ras_unf,
   output logic              misalign,
   output logic              exc_taken
);

   localparam int              PTR_W   = $clog2(RAS_DEPTH);
   localparam int              CNT_W   = PTR_W + 1;
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

   localparam logic [2:0] SRC_SEQ  = 3'b000;
   localparam logic [2:0] SRC_BR   = 3'b001;
   localparam logic [2:0] SRC_JR   = 3'b010;
   localparam logic [2:0] SRC_J    = 3'b011;
   localparam logic [2:0] SRC_RET  = 3'b100;
   localparam logic [2:0] SRC_ERET = 3'b101;

   logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]  ras_ptr;
   logic [CNT_W-1:0]  ras_cnt;
   logic [PTR_W-1:0]  ras_top_idx;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] br_off;
   logic              is_ret;
   logic              do_push;
   logic              do_pop;
   logic              do_both;
   logic              take_exc;
   logic              do_update;
   logic              ras_we;
   logic [PTR_W-1:0]  ras_waddr;

   assign PC_add_4    = Address + ADDR_W'(4);
   assign PC4         = Address[31:28];
   assign ras_empty   = (ras_cnt == '0);
   assign ras_full    = (ras_cnt == DEPTH_C);
   assign ras_top_idx = ras_ptr - PTR_ONE;
   assign ras_top     = ras_mem[ras_top_idx];
   assign br_off      = {{(ADDR_W-18){Immediate[15]}}, Immediate, 2'b00};

   always_comb begin
      nextPC = PC_add_4;
      case (PCSrc)
         SRC_SEQ:  nextPC = PC_add_4;
         SRC_BR:   nextPC = PC_add_4 + br_off;
         SRC_JR:   nextPC = dataFromRs;
         SRC_J:    nextPC = {PC_add_4[ADDR_W-1:28], JumpIdx, 2'b00};
         SRC_RET:  nextPC = ras_empty ? dataFromRs : ras_top;
         SRC_ERET: nextPC = EPC;
         default:  nextPC = PC_add_4;
      endcase
   end

   assign misalign  = (nextPC[1:0] != 2'b00);
   assign is_ret    = (PCSrc == SRC_RET);
   assign do_push   = push_ra && !is_ret;
   assign do_pop    = is_ret && !push_ra;
   assign do_both   = is_ret && push_ra;
   assign take_exc  = exc_req || (PCWre && misalign);
   assign do_update = PCWre && !take_exc;

   // Combined pop+push on a non-empty stack rewrites the current top in place.
   assign ras_we    = do_update && (do_push || do_both);
   assign ras_waddr = (do_both && !ras_empty) ? ras_top_idx : ras_ptr;

   always_ff @(posedge CLK) begin
      if (ras_we && Reset) begin
         ras_mem[ras_waddr] <= PC_add_4;
      end
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         Address   <= RESET_VECTOR;
         EPC       <= '0;
         ras_ptr   <= '0;
         ras_cnt   <= '0;
         ras_ovf   <= 1'b0;
         ras_unf   <= 1'b0;
         exc_taken <= 1'b0;
      end else if (take_exc) begin
         EPC       <= Address;
         Address   <= EXC_VECTOR;
         exc_taken <= 1'b1;
      end else if (PCWre) begin
         Address   <= nextPC;
         exc_taken <= 1'b0;
         if (do_push) begin
            ras_ptr <= ras_ptr + PTR_ONE;
            if (ras_full) begin
               ras_ovf <= 1'b1;
            end else begin
               ras_cnt <= ras_cnt + CNT_ONE;
            end
         end else if (do_pop) begin
            if (!ras_empty) begin
               ras_ptr <= ras_ptr - PTR_ONE;
               ras_cnt <= ras_cnt - CNT_ONE;
            end else begin
               ras_unf <= 1'b1;
            end
         end else if (do_both && ras_empty) begin
            ras_ptr <= ras_ptr + PTR_ONE;
            ras_cnt <= ras_cnt + CNT_ONE;
            ras_unf <= 1'b1;
         end
      end else begin
         exc_taken <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed self-checking bench for pc_unit_ras with default parameters.
module tb_pc_unit_ras;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        PCWre = 1'b0;
   logic [2:0]  PCSrc = 3'b000;
   logic [15:0] Immediate = '0;
   logic [31:0] dataFromRs = '0;
   logic [25:0] JumpIdx = '0;
   logic        push_ra = 1'b0;
   logic        exc_req = 1'b0;
   logic [31:0] Address, nextPC, PC_add_4, EPC;
   logic [3:0]  PC4;
   logic        ras_empty, ras_full, ras_ovf, ras_unf, misalign, exc_taken;

   int total = 0;
   int bad = 0;

   pc_unit_ras dut (
      .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc),
      .Immediate(Immediate), .dataFromRs(dataFromRs), .JumpIdx(JumpIdx),
      .push_ra(push_ra), .exc_req(exc_req), .Address(Address),
      .nextPC(nextPC), .PC_add_4(PC_add_4), .PC4(PC4), .EPC(EPC),
      .ras_empty(ras_empty), .ras_full(ras_full), .ras_ovf(ras_ovf),
      .ras_unf(ras_unf), .misalign(misalign), .exc_taken(exc_taken)
   );

   always #5 CLK = ~CLK;

   task automatic drive(input logic [2:0] src, input logic we, input logic push,
                        input logic [31:0] rs, input logic [15:0] imm,
                        input logic [25:0] jidx, input logic exc);
      PCSrc = src; PCWre = we; push_ra = push; dataFromRs = rs;
      Immediate = imm; JumpIdx = jidx; exc_req = exc;
      #1;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      drive(3'b000, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
      Reset = 1'b0;
      #3;
      Reset = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (Address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=%h", Address, 32'h0); end
      total++; if (EPC !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=%h", EPC, 32'h0); end
      total++; if (PC_add_4 !== 32'h4) begin bad++; $display("FAIL reset_pc4 got=%h exp=%h", PC_add_4, 32'h4); end
      total++; if ({ras_empty, ras_full, ras_ovf, ras_unf, exc_taken} !== 5'b10000) begin
         bad++; $display("FAIL reset_flags got=%b exp=%b", {ras_empty, ras_full, ras_ovf, ras_unf, exc_taken}, 5'b10000); end
   endtask

   task automatic test_seq();
      do_reset();
      drive(3'b000, 1'b1, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
      total++; if (nextPC !== 32'h4) begin bad++; $display("FAIL seq_next got=%h exp=%h", nextPC, 32'h4); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++; if (Address !== 32'(4*i)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, Address, 32'(4*i)); end
      end
      #2;
      Reset = 1'b0;
      #1;
      total++; if (Address !== 32'h0) begin bad++; $display("FAIL async_reset got=%h exp=%h", Address, 32'h0); end
      Reset = 1'b1;
   endtask

   task automatic test_branch_jump();
      do_reset();
      drive(3'b010, 1'b1, 1'b0, 32'h40, 16'h0, 26'h0, 1'b0); tick();
      drive(3'b001, 1'b1, 1'b0, 32'h0, 16'hFFFE, 26'h0, 1'b0);
      total++; if (nextPC !== 32'h3C) begin bad++; $display("FAIL br_neg_next got=%h exp=%h", nextPC, 32'h3C); end
      tick();
      total++; if (Address !== 32'h3C) begin bad++; $display("FAIL br_neg got=%h exp=%h", Address, 32'h3C); end
      drive(3'b010, 1'b1, 1'b0, 32'h40, 16'h0, 26'h0, 1'b0); tick();
      drive(3'b001, 1'b1, 1'b0, 32'h0, 16'h0003, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h50) begin bad++; $display("FAIL br_pos got=%h exp=%h", Address, 32'h50); end
      drive(3'b010, 1'b1, 1'b0, 32'h1000_0000, 16'h0, 26'h0, 1'b0); tick();
      total++; if (PC4 !== 4'h1) begin bad++; $display("FAIL pc4 got=%h exp=%h", PC4, 4'h1); end
      drive(3'b011, 1'b1, 1'b0, 32'h0, 16'h0, 26'h40, 1'b0); tick();
      total++; if (Address !== 32'h1000_0100) begin bad++; $display("FAIL jump got=%h exp=%h", Address, 32'h1000_0100); end
      drive(3'b110, 1'b1, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h1000_0104) begin bad++; $display("FAIL reserved_seq got=%h exp=%h", Address, 32'h1000_0104); end
      drive(3'b000, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h1000_0104) begin bad++; $display("FAIL hold got=%h exp=%h", Address, 32'h1000_0104); end
   endtask

   task automatic test_call_ret();
      do_reset();
      drive(3'b010, 1'b1, 1'b0, 32'h100, 16'h0, 26'h0, 1'b0); tick();
      drive(3'b011, 1'b1, 1'b1, 32'h0, 16'h0, 26'h80, 1'b0); tick();
      total++; if (Address !== 32'h200) begin bad++; $display("FAIL jal_addr got=%h exp=%h", Address, 32'h200); end
      total++; if (ras_empty !== 1'b0) begin bad++; $display("FAIL jal_nonempty got=%b exp=%b", ras_empty, 1'b0); end
      drive(3'b100, 1'b1, 1'b0, 32'h300, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h104) begin bad++; $display("FAIL ret_addr got=%h exp=%h", Address, 32'h104); end
      total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL ret_empty got=%b exp=%b", ras_empty, 1'b1); end
      total++; if (ras_unf !== 1'b0) begin bad++; $display("FAIL ret_no_unf got=%b exp=%b", ras_unf, 1'b0); end
      drive(3'b100, 1'b1, 1'b0, 32'h300, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h300) begin bad++; $display("FAIL ret_fallback got=%h exp=%h", Address, 32'h300); end
      total++; if (ras_unf !== 1'b1) begin bad++; $display("FAIL ret_unf got=%b exp=%b", ras_unf, 1'b1); end
   endtask

   task automatic test_ras_overflow();
      logic [31:0] exp_pop [4] = '{32'h50, 32'h40, 32'h30, 32'h20};
      do_reset();
      drive(3'b010, 1'b1, 1'b0, 32'h0C, 16'h0, 26'h0, 1'b0); tick();
      for (int i = 0; i < 5; i++) begin
         drive(3'b010, 1'b1, 1'b1, 32'(16*i + 32'h1C), 16'h0, 26'h0, 1'b0); tick();
      end
      total++; if (ras_full !== 1'b1) begin bad++; $display("FAIL ovf_full got=%b exp=%b", ras_full, 1'b1); end
      total++; if (ras_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", ras_ovf, 1'b1); end
      for (int i = 0; i < 4; i++) begin
         drive(3'b100, 1'b1, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0);
         total++; if (nextPC !== exp_pop[i]) begin bad++; $display("FAIL pop%0d got=%h exp=%h", i, nextPC, exp_pop[i]); end
         tick();
      end
      total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL pop_empty got=%b exp=%b", ras_empty, 1'b1); end
      total++; if (ras_unf !== 1'b0) begin bad++; $display("FAIL pop_no_unf got=%b exp=%b", ras_unf, 1'b0); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(3'b010, 1'b1, 1'b0, 32'h100, 16'h0, 26'h0, 1'b0); tick();
      drive(3'b011, 1'b1, 1'b1, 32'h0, 16'h0, 26'h80, 1'b0); tick();
      drive(3'b100, 1'b1, 1'b1, 32'h0, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h104) begin bad++; $display("FAIL popush_addr got=%h exp=%h", Address, 32'h104); end
      drive(3'b100, 1'b1, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h204) begin bad++; $display("FAIL popush_top got=%h exp=%h", Address, 32'h204); end
      total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL popush_empty got=%b exp=%b", ras_empty, 1'b1); end
   endtask

   task automatic test_misalign();
      do_reset();
      drive(3'b010, 1'b1, 1'b0, 32'h80, 16'h0, 26'h0, 1'b0); tick();
      drive(3'b010, 1'b1, 1'b0, 32'h202, 16'h0, 26'h0, 1'b0);
      total++; if (misalign !== 1'b1) begin bad++; $display("FAIL misalign_comb got=%b exp=%b", misalign, 1'b1); end
      tick();
      total++; if (Address !== 32'h180) begin bad++; $display("FAIL mis_addr got=%h exp=%h", Address, 32'h180); end
      total++; if (EPC !== 32'h80) begin bad++; $display("FAIL mis_epc got=%h exp=%h", EPC, 32'h80); end
      total++; if (exc_taken !== 1'b1) begin bad++; $display("FAIL mis_pulse got=%b exp=%b", exc_taken, 1'b1); end
      drive(3'b000, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0); tick();
      total++; if (exc_taken !== 1'b0) begin bad++; $display("FAIL mis_pulse_end got=%b exp=%b", exc_taken, 1'b0); end
      total++; if (Address !== 32'h180) begin bad++; $display("FAIL mis_hold got=%h exp=%h", Address, 32'h180); end
      drive(3'b101, 1'b1, 1'b0, 32'h0, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h80) begin bad++; $display("FAIL eret got=%h exp=%h", Address, 32'h80); end
   endtask

   task automatic test_exc_req();
      do_reset();
      drive(3'b010, 1'b1, 1'b0, 32'h20, 16'h0, 26'h0, 1'b0); tick();
      drive(3'b000, 1'b0, 1'b0, 32'h0, 16'h0, 26'h0, 1'b1); tick();
      total++; if (Address !== 32'h180) begin bad++; $display("FAIL excreq_addr got=%h exp=%h", Address, 32'h180); end
      total++; if (EPC !== 32'h20) begin bad++; $display("FAIL excreq_epc got=%h exp=%h", EPC, 32'h20); end
      total++; if (exc_taken !== 1'b1) begin bad++; $display("FAIL excreq_pulse got=%b exp=%b", exc_taken, 1'b1); end
      drive(3'b011, 1'b1, 1'b1, 32'h0, 16'h0, 26'h80, 1'b1); tick();
      total++; if (Address !== 32'h180) begin bad++; $display("FAIL excjal_addr got=%h exp=%h", Address, 32'h180); end
      total++; if (EPC !== 32'h180) begin bad++; $display("FAIL excjal_epc got=%h exp=%h", EPC, 32'h180); end
      total++; if (ras_empty !== 1'b1) begin bad++; $display("FAIL excjal_ras got=%b exp=%b", ras_empty, 1'b1); end
      drive(3'b100, 1'b1, 1'b0, 32'h3F0, 16'h0, 26'h0, 1'b0); tick();
      total++; if (Address !== 32'h3F0) begin bad++; $display("FAIL excjal_ret got=%h exp=%h", Address, 32'h3F0); end
   endtask

   initial begin
      test_reset();
      test_seq();
      test_branch_jump();
      test_call_ret();
      test_ras_overflow();
      test_back_to_back();
      test_misalign();
      test_exc_req();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit for the multicycle CPU, successor to the basic PC register. It adds width/vector parameters and a wider next-PC selection, including exception entry and return (EPC). It also carries a circular return-address stack (RAS) that pushes on calls and pops on returns, plus misaligned-target trapping. It sits between the control unit (PCWre/PCSrc), the register file (rs data) and instruction memory (Address).

Parameters:
ADDR_W, 32, PC width; legal values >= 32.
RESET_VECTOR, 0, Address value after reset.
EXC_VECTOR, 32'h0000_0180, Address loaded on exception entry.
RAS_DEPTH, 4, number of RAS entries; power of 2, >= 2.

Ports:
CLK  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-low reset.
PCWre  in  1  PC update enable; all state changes are gated by it, except exception entry.
PCSrc  in  3  000 seq, 001 branch, 010 jr (rs), 011 j/jal, 100 ret (RAS pop), 101 eret, 11x reserved (treated as seq).
Immediate  in  16  signed branch offset, in words.
dataFromRs  in  ADDR_W  rs register value.
JumpIdx  in  26  instr_index field.
push_ra  in  1  call marker (jal); pushes PC_add_4 on update.
exc_req  in  1  external exception request.
Address  out  ADDR_W  current PC (register).
nextPC  out  ADDR_W  combinational selected target.
PC_add_4  out  ADDR_W  Address+4.
PC4  out  4  Address[31:28].
EPC  out  ADDR_W  exception PC register.
ras_empty  out  1  RAS count == 0.
ras_full  out  1  RAS count == RAS_DEPTH.
ras_ovf  out  1  sticky: a push happened while full.
ras_unf  out  1  sticky: a pop happened while empty.
misalign  out  1  combinational: nextPC[1:0] != 0.
exc_taken  out  1  registered one-cycle pulse on exception entry.

Behaviour:
- Reset low (async): Address=RESET_VECTOR; EPC=0; RAS ptr=0 and count=0; ras_ovf=ras_unf=0; exc_taken=0. RAS entry contents are don't-care. Reset mid-operation aborts any update and applies the same values.
- nextPC (combinational), by PCSrc:
  - seq: Address+4.
  - branch: Address+4+(sign_ext(Immediate)<<2), modulo 2^ADDR_W.
  - jr: dataFromRs.
  - j: {PC_add_4[ADDR_W-1:28], JumpIdx, 2'b00}.
  - ret: RAS top if count>0, else dataFromRs (fallback).
  - eret: EPC.
  - reserved codes: Address+4.
- Rising edge, priority order:
  1. exc_req=1 (independent of PCWre): EPC<=Address; Address<=EXC_VECTOR; exc_taken<=1; RAS unchanged.
  2. Else if PCWre and misalign: EPC<=Address; Address<=EXC_VECTOR; exc_taken<=1; RAS unchanged.
  3. Else if PCWre: Address<=nextPC; exc_taken<=0; RAS updated as below.
  4. Else: hold all state; exc_taken<=0.
- RAS, applied only in case 3:
  - Push (push_ra and PCSrc!=ret): entry[ptr]<=PC_add_4; ptr<=ptr+1 mod RAS_DEPTH; count<=min(count+1, RAS_DEPTH). If already full, the oldest entry is overwritten and ras_ovf<=1.
  - Pop (PCSrc==ret, push_ra=0): if count>0, ptr<=ptr-1 and count<=count-1. If empty, set ras_unf<=1; ptr and count stay unchanged.
  - Pop and push together: target is the old top; the top entry is replaced with PC_add_4; ptr and count unchanged. If empty, this behaves as a push and sets ras_unf.
- RAS top is entry[ptr-1 mod RAS_DEPTH].
- Sticky flags clear only on reset.
- Latency: Address reflects nextPC one edge after PCWre. nextPC follows inputs with zero cycles of delay.

Test Plan:
- Reset released, PCWre=1, seq x3 -> Address 0, 4, 8, 12. Reset low mid-run -> Address=0 immediately, without waiting for a clock edge.
- Address=0x40, branch with Immediate=16'hFFFE -> Address=0x3C. Immediate=3 -> 0x50. Address=0x1000_0000, j with JumpIdx=0x40 -> 0x1000_0100.
- Address=0x100, jal (j + push_ra) to 0x200, then ret -> Address=0x104, ras_empty=1. A second ret with dataFromRs=0x300 -> Address=0x300, ras_unf=1.
- RAS_DEPTH=4, five pushes of PC_add_4 = 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1, ras_ovf=1. Then four pops yield 0x50, 0x40, 0x30, 0x20, and ras_empty=1.
- Address=0x80, jr with dataFromRs=0x202 -> Address=0x180, EPC=0x80, exc_taken pulses for exactly 1 cycle. Then eret -> Address=0x80.
- exc_req=1 with PCWre=0 -> exception still taken. exc_req=1 and a jal in the same cycle -> exception taken, RAS count unchanged.
